// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Purpose  : Shared constants for the multicycle accumulator controller:
//             opcodes, ALU function codes, state encoding, select values.
//  Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

    // Instruction opcodes (IR[7:5])
    localparam logic [2:0] C_OP_ADD = 3'b000;
    localparam logic [2:0] C_OP_SUB = 3'b001;
    localparam logic [2:0] C_OP_AND = 3'b010;
    localparam logic [2:0] C_OP_NOT = 3'b011;
    localparam logic [2:0] C_OP_LDA = 3'b100;
    localparam logic [2:0] C_OP_STA = 3'b101;
    localparam logic [2:0] C_OP_JMP = 3'b110;
    localparam logic [2:0] C_OP_JZ  = 3'b111;

    // ALU function codes, shared with the datapath ALU
    localparam logic [1:0] C_ALU_ADD = 2'b00;
    localparam logic [1:0] C_ALU_SUB = 2'b01;
    localparam logic [1:0] C_ALU_AND = 2'b10;
    localparam logic [1:0] C_ALU_NOT = 2'b11;

    // Controller states; the encoding is visible on the debug state port
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_EXEC   = 3'd3,
        ST_LDA_WB = 3'd4,
        ST_STORE  = 3'd5,
        ST_JUMP   = 3'd6
    } state_t;

    // Mux select values
    localparam logic C_ADDR_PC     = 1'b0;
    localparam logic C_ADDR_IR     = 1'b1;
    localparam logic C_PC_SRC_ALU  = 1'b0;
    localparam logic C_PC_SRC_IR   = 1'b1;
    localparam logic C_SRC_A_PC    = 1'b0;
    localparam logic C_SRC_A_ACC   = 1'b1;
    localparam logic C_SRC_B_ONE   = 1'b0;
    localparam logic C_SRC_B_MDR   = 1'b1;
    localparam logic C_ACC_SRC_ALU = 1'b0;
    localparam logic C_ACC_SRC_MDR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mc_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_controller_if
//  Purpose  : Control bus between the multicycle controller (master) and the
//             accumulator datapath / memory side (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface mc_controller_if;

    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       mdr_write;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_func;
    logic       acc_write;
    logic       acc_src;
    logic [2:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, mdr_write, pc_write,
               pc_src, alu_src_a, alu_src_b, alu_func, acc_write, acc_src,
               state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, mdr_write, pc_write,
               pc_src, alu_src_a, alu_src_b, alu_func, acc_write, acc_src,
               state
    );

endinterface
`default_nettype wire

// File: rtl/mc_next_state.sv
`default_nettype none
// ============================================================================
//  Module   : mc_next_state
//  Purpose  : Purely combinational next-state function of the multicycle
//             controller.
//  Revision : 1.0  initial release
// ============================================================================
module mc_next_state
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] opcode,
    input  logic       mem_ready,
    output state_t     next_state
);

    // Sequence the instruction phases; memory states hold until mem_ready
    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH: begin
                if (mem_ready) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_LDA: next_state = ST_MEM_RD;
                    C_OP_NOT:                               next_state = ST_EXEC;
                    C_OP_STA:                               next_state = ST_STORE;
                    default:                                next_state = ST_JUMP;
                endcase
            end
            ST_MEM_RD: begin
                if (mem_ready) next_state = (opcode == C_OP_LDA) ? ST_LDA_WB : ST_EXEC;
            end
            ST_EXEC:   next_state = ST_FETCH;
            ST_LDA_WB: next_state = ST_FETCH;
            ST_STORE: begin
                if (mem_ready) next_state = ST_FETCH;
            end
            ST_JUMP:   next_state = ST_FETCH;
            default:   next_state = ST_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mc_controller
//  Purpose  : Multicycle control unit for the 8-bit accumulator datapath.
//             Holds the state register and decodes all datapath controls.
//  Revision : 1.0  initial release
// ============================================================================
module mc_controller
    import mc_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    mc_controller_if.master bus
);

    state_t     r_state;
    state_t     w_next_state;

    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_i_or_d;
    logic       w_ir_write;
    logic       w_mdr_write;
    logic       w_pc_write;
    logic       w_pc_src;
    logic       w_alu_src_a;
    logic       w_alu_src_b;
    logic [1:0] w_alu_func;
    logic       w_acc_write;
    logic       w_acc_src;

    mc_next_state u_next_state (
        .state      (r_state),
        .opcode     (bus.opcode),
        .mem_ready  (bus.mem_ready),
        .next_state (w_next_state)
    );

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Output decode; strobes are masked while rst is high so a reset cycle
    // never commits a write, even if it lands on a mem_ready
    always_comb begin
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_i_or_d    = C_ADDR_PC;
        w_ir_write  = 1'b0;
        w_mdr_write = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = C_PC_SRC_ALU;
        w_alu_src_a = C_SRC_A_PC;
        w_alu_src_b = C_SRC_B_ONE;
        w_alu_func  = C_ALU_ADD;
        w_acc_write = 1'b0;
        w_acc_src   = C_ACC_SRC_ALU;
        case (r_state)
            ST_FETCH: begin
                // PC+1 is computed every cycle but only loaded with the IR
                w_mem_read  = 1'b1;
                w_i_or_d    = C_ADDR_PC;
                w_alu_src_a = C_SRC_A_PC;
                w_alu_src_b = C_SRC_B_ONE;
                w_alu_func  = C_ALU_ADD;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
                w_pc_src    = C_PC_SRC_ALU;
            end
            ST_MEM_RD: begin
                w_mem_read  = 1'b1;
                w_i_or_d    = C_ADDR_IR;
                w_mdr_write = bus.mem_ready;
            end
            ST_EXEC: begin
                // Arithmetic opcodes map directly onto ALU function codes
                w_alu_src_a = C_SRC_A_ACC;
                w_alu_src_b = C_SRC_B_MDR;
                w_alu_func  = bus.opcode[1:0];
                w_acc_write = 1'b1;
                w_acc_src   = C_ACC_SRC_ALU;
            end
            ST_LDA_WB: begin
                w_acc_write = 1'b1;
                w_acc_src   = C_ACC_SRC_MDR;
            end
            ST_STORE: begin
                w_mem_write = 1'b1;
                w_i_or_d    = C_ADDR_IR;
            end
            ST_JUMP: begin
                w_pc_src   = C_PC_SRC_IR;
                w_pc_write = (bus.opcode == C_OP_JMP) ||
                             ((bus.opcode == C_OP_JZ) && bus.zero);
            end
            default: begin
            end
        endcase
        if (rst) begin
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_ir_write  = 1'b0;
            w_mdr_write = 1'b0;
            w_pc_write  = 1'b0;
            w_acc_write = 1'b0;
        end
    end

    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.i_or_d    = w_i_or_d;
    assign bus.ir_write  = w_ir_write;
    assign bus.mdr_write = w_mdr_write;
    assign bus.pc_write  = w_pc_write;
    assign bus.pc_src    = w_pc_src;
    assign bus.alu_src_a = w_alu_src_a;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.alu_func  = w_alu_func;
    assign bus.acc_write = w_acc_write;
    assign bus.acc_src   = w_acc_src;
    assign bus.state     = r_state;

endmodule
`default_nettype wire
